// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: drains a FIFO to a valid/ready stream in bursts of up to BURST_LEN beats.
// Latency: read strobe 1 cycle after the trigger, beat valid 3 cycles after it; 3 cycles per beat.
// Backpressure: holds the beat (valid/data/last stable) while out_ready is low; no read meanwhile.
// Ports: clk/reset (async, active-high); enable, thresh, fifo_count, fifo_empty select when a burst
// starts; fifo_rd_en/fifo_rd_data form the FIFO read port; out_valid/out_ready/out_data/out_last
// are the downstream stream; busy is high whenever a burst is in progress.
module fifo_drain_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 9,
  parameter int BURST_LEN  = 16,
  parameter int TIMEOUT    = 200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [CNT_WIDTH-1:0]  thresh,
  input  logic [CNT_WIDTH-1:0]  fifo_count,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RD, CAP, SEND} state_t;

  state_t     state;
  logic [7:0] beats_left;
  logic [7:0] idle_timer;

  logic       thresh_hit;
  logic       timeout_hit;
  logic       trigger;
  logic [7:0] burst_beats;

  always_comb begin
    thresh_hit  = (thresh != '0) && (fifo_count >= thresh);
    timeout_hit = (idle_timer == 8'(TIMEOUT));
    trigger     = enable && !fifo_empty && (thresh_hit || timeout_hit);
    // A non-empty FIFO holds at least one entry; never latch a zero-beat
    // burst even if the count input lags the empty flag.
    if (32'(fifo_count) >= BURST_LEN)
      burst_beats = 8'(BURST_LEN);
    else if (fifo_count == '0)
      burst_beats = 8'd1;
    else
      burst_beats = 8'(fifo_count);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      beats_left <= '0;
      idle_timer <= '0;
      out_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            beats_left <= burst_beats;
            idle_timer <= '0;
            state      <= RD;
          end else if (enable && !fifo_empty) begin
            if (idle_timer != 8'(TIMEOUT))
              idle_timer <= idle_timer + 8'd1;
          end else begin
            idle_timer <= '0;
          end
        end
        RD: begin
          // Count the beat when it is read, so SEND sees 0 on the final beat.
          beats_left <= beats_left - 8'd1;
          state      <= CAP;
        end
        CAP: begin
          out_data <= fifo_rd_data;
          state    <= SEND;
        end
        SEND: begin
          if (out_ready)
            state <= (beats_left != 8'd0) ? RD : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Control outputs depend only on registered state, never on inputs.
  assign fifo_rd_en = (state == RD);
  assign out_valid  = (state == SEND);
  assign out_last   = (state == SEND) && (beats_left == 8'd0);
  assign busy       = (state != IDLE);

endmodule
